// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue feeding the register file write port.
// Buffers execute/memory results, drains one per clock, and exposes pending/forwarding for decode.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_W-1:0]              in_reg,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           drain_en,
    output logic                           rf_write_en,
    output logic [ADDR_W-1:0]              rf_write_reg,
    output logic [DATA_W-1:0]              rf_write_data,
    input  logic [ADDR_W-1:0]              chk_reg_1,
    input  logic [ADDR_W-1:0]              chk_reg_2,
    output logic                           fwd_hit_1,
    output logic [DATA_W-1:0]              fwd_data_1,
    output logic                           fwd_hit_2,
    output logic [DATA_W-1:0]              fwd_data_2,
    output logic [(1<<ADDR_W)-1:0]         pending,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] q_reg  [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  slot_idx [DEPTH];
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH-1)) return '0;
        return p + 1'b1;
    endfunction

    assign in_ready    = reset && (count < CNT_W'(DEPTH));
    assign push        = in_valid && in_ready;
    assign rf_write_en = reset && drain_en && (count != '0);
    assign pop         = rf_write_en;

    assign rf_write_reg  = (count != '0) ? q_reg[head]  : '0;
    assign rf_write_data = (count != '0) ? q_data[head] : '0;

    // slot_idx[k] is the physical slot of the k-th oldest entry
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            logic [PTR_W:0] sum;
            sum = {1'b0, head} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(DEPTH)) sum = sum - (PTR_W+1)'(DEPTH);
            slot_idx[k] = sum[PTR_W-1:0];
        end
    end

    // Walk oldest to youngest so the last match wins for forwarding
    always_comb begin
        pending    = '0;
        fwd_hit_1  = 1'b0;
        fwd_data_1 = '0;
        fwd_hit_2  = 1'b0;
        fwd_data_2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < count) begin
                pending[q_reg[slot_idx[k]]] = 1'b1;
                if (q_reg[slot_idx[k]] == chk_reg_1) begin
                    fwd_hit_1  = 1'b1;
                    fwd_data_1 = q_data[slot_idx[k]];
                end
                if (q_reg[slot_idx[k]] == chk_reg_2) begin
                    fwd_hit_2  = 1'b1;
                    fwd_data_2 = q_data[slot_idx[k]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                q_reg[tail]  <= in_reg;
                q_data[tail] <= in_data;
                tail         <= ptr_inc(tail);
            end
            if (pop) head <= ptr_inc(head);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: inputs driven and outputs sampled on the falling edge.
module tb_regfile_writeback_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_reg;
    logic [7:0] in_data;
    logic       drain_en;
    logic       rf_write_en;
    logic [2:0] rf_write_reg;
    logic [7:0] rf_write_data;
    logic [2:0] chk_reg_1;
    logic [2:0] chk_reg_2;
    logic       fwd_hit_1;
    logic [7:0] fwd_data_1;
    logic       fwd_hit_2;
    logic [7:0] fwd_data_2;
    logic [7:0] pending;
    logic [2:0] count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_writeback_queue #(.DEPTH(4), .DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .drain_en(drain_en),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .chk_reg_1(chk_reg_1), .chk_reg_2(chk_reg_2),
        .fwd_hit_1(fwd_hit_1), .fwd_data_1(fwd_data_1),
        .fwd_hit_2(fwd_hit_2), .fwd_data_2(fwd_data_2),
        .pending(pending), .count(count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [2:0] r, input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    logic [2:0] exp_reg  [13];
    logic [7:0] exp_data [13];
    logic [2:0] s6_reg   [3];
    logic [7:0] s6_data  [3];
    logic       s6_drain [6];
    logic       s6_h1    [6];
    logic [7:0] s6_d1    [6];
    logic       s6_h2    [6];
    logic [7:0] s6_d2    [6];

    initial begin
        int nw;
        int w6;

        reset = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0;
        drain_en = 1'b1; chk_reg_1 = '0; chk_reg_2 = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_wr_en", 32'(rf_write_en), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rel_in_ready", 32'(in_ready), 32'd1);
        check_val("rel_pending", 32'(pending), 32'h00);
        check_val("rel_wr_reg", 32'(rf_write_reg), 32'd0);
        check_val("rel_wr_data", 32'(rf_write_data), 32'd0);
        check_val("rel_fwd1", 32'({fwd_hit_1, fwd_data_1}), 32'd0);
        check_val("rel_fwd2", 32'({fwd_hit_2, fwd_data_2}), 32'd0);

        // ---- case 1: single write-through ----
        push_one(3'd3, 8'hA5);
        #1;
        check_val("c1_no_bypass", 32'(rf_write_en), 32'd0);
        idle_cycle();
        check_val("c1_wr_en", 32'(rf_write_en), 32'd1);
        check_val("c1_wr_reg", 32'(rf_write_reg), 32'd3);
        check_val("c1_wr_data", 32'(rf_write_data), 32'hA5);
        check_val("c1_pending", 32'(pending), 32'h08);
        idle_cycle();
        check_val("c1_wr_en_after", 32'(rf_write_en), 32'd0);
        check_val("c1_count_after", 32'(count), 32'd0);
        check_val("c1_pending_after", 32'(pending), 32'h00);

        // ---- case 2: fill with drain held off ----
        drain_en = 1'b0;
        push_one(3'd1, 8'h11);
        push_one(3'd2, 8'h22);
        push_one(3'd1, 8'h33);
        push_one(3'd7, 8'h77);
        push_one(3'd4, 8'h44);
        #1;
        check_val("c2_count_full", 32'(count), 32'd4);
        check_val("c2_in_ready", 32'(in_ready), 32'd0);
        idle_cycle();
        chk_reg_1 = 3'd1; chk_reg_2 = 3'd5;
        #1;
        check_val("c2_count_5th", 32'(count), 32'd4);
        check_val("c2_pending", 32'(pending), 32'h86);
        check_val("c2_hit1", 32'(fwd_hit_1), 32'd1);
        check_val("c2_data1", 32'(fwd_data_1), 32'h33);
        check_val("c2_hit2", 32'(fwd_hit_2), 32'd0);
        check_val("c2_data2", 32'(fwd_data_2), 32'h00);
        check_val("c2_held_wr_en", 32'(rf_write_en), 32'd0);

        // ---- case 3: drain four ----
        exp_reg[0] = 3'd1; exp_data[0] = 8'h11;
        exp_reg[1] = 3'd2; exp_data[1] = 8'h22;
        exp_reg[2] = 3'd1; exp_data[2] = 8'h33;
        exp_reg[3] = 3'd7; exp_data[3] = 8'h77;
        @(negedge clk);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check_val($sformatf("c3_wr_en_%0d", i), 32'(rf_write_en), 32'd1);
            check_val($sformatf("c3_wr_%0d", i), 32'({rf_write_reg, rf_write_data}),
                      32'({exp_reg[i], exp_data[i]}));
            if (i == 0) check_val("c3_in_ready_full", 32'(in_ready), 32'd0);
            if (i == 1) check_val("c3_in_ready_after_pop", 32'(in_ready), 32'd1);
            if (i == 2) check_val("c3_fwd1_head", 32'({fwd_hit_1, fwd_data_1}), 32'h133);
            if (i == 3) check_val("c3_hit1_gone", 32'(fwd_hit_1), 32'd0);
        end
        idle_cycle();
        check_val("c3_wr_en_done", 32'(rf_write_en), 32'd0);
        check_val("c3_count_done", 32'(count), 32'd0);

        // ---- case 4: push during pop, then stream with wrap ----
        exp_reg[0] = 3'd5; exp_data[0] = 8'h50;
        exp_reg[1] = 3'd6; exp_data[1] = 8'h60;
        exp_reg[2] = 3'd0; exp_data[2] = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            exp_reg[k+2]  = 3'(k % 8);
            exp_data[k+2] = 8'(8'h80 + k);
        end
        drain_en = 1'b0;
        push_one(3'd5, 8'h50);
        push_one(3'd6, 8'h60);
        nw = 0;
        for (int c = 0; c < 40 && nw < 13; c++) begin
            @(negedge clk);
            drain_en = 1'b1;
            if (c < 11) begin
                in_valid = 1'b1;
                in_reg   = exp_reg[c+2];
                in_data  = exp_data[c+2];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 1) check_val("c4_count_push_pop", 32'(count), 32'd2);
            if (c == 6) check_val("c4_count_stream", 32'(count), 32'd2);
            if (c < 11 && !in_ready) check_val($sformatf("c4_in_ready_%0d", c), 32'(in_ready), 32'd1);
            if (rf_write_en) begin
                check_val($sformatf("c4_wr_%0d", nw), 32'({rf_write_reg, rf_write_data}),
                          32'({exp_reg[nw], exp_data[nw]}));
                nw++;
            end
        end
        check_val("c4_write_total", 32'(nw), 32'd13);
        idle_cycle();
        check_val("c4_count_end", 32'(count), 32'd0);
        check_val("c4_wr_en_end", 32'(rf_write_en), 32'd0);

        // ---- case 5: reset mid-operation ----
        drain_en = 1'b0;
        push_one(3'd1, 8'h91);
        push_one(3'd2, 8'h92);
        push_one(3'd3, 8'h93);
        @(negedge clk);
        reset = 1'b0; drain_en = 1'b1;
        in_valid = 1'b1; in_reg = 3'd4; in_data = 8'h94;
        #1;
        check_val("c5_rst_wr_en", 32'(rf_write_en), 32'd0);
        check_val("c5_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check_val("c5_count", 32'(count), 32'd0);
        check_val("c5_pending", 32'(pending), 32'h00);
        check_val("c5_in_ready", 32'(in_ready), 32'd1);
        nw = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (rf_write_en) nw++;
        end
        check_val("c5_no_stale_writes", 32'(nw), 32'd0);

        // ---- case 6: drain_en toggling ----
        s6_reg[0] = 3'd2; s6_data[0] = 8'h21;
        s6_reg[1] = 3'd5; s6_data[1] = 8'h52;
        s6_reg[2] = 3'd2; s6_data[2] = 8'h23;
        s6_drain = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        s6_h1    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        s6_d1    = '{8'h23, 8'h23, 8'h23, 8'h23, 8'h23, 8'h00};
        s6_h2    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        s6_d2    = '{8'h52, 8'h52, 8'h52, 8'h00, 8'h00, 8'h00};
        drain_en = 1'b0;
        chk_reg_1 = 3'd2; chk_reg_2 = 3'd5;
        for (int i = 0; i < 3; i++) push_one(s6_reg[i], s6_data[i]);
        w6 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            drain_en = s6_drain[i];
            #1;
            check_val($sformatf("c6_wr_en_%0d", i), 32'(rf_write_en), 32'(s6_drain[i] && (w6 < 3)));
            check_val($sformatf("c6_fwd1_%0d", i), 32'({fwd_hit_1, fwd_data_1}), 32'({s6_h1[i], s6_d1[i]}));
            check_val($sformatf("c6_fwd2_%0d", i), 32'({fwd_hit_2, fwd_data_2}), 32'({s6_h2[i], s6_d2[i]}));
            if (rf_write_en && w6 < 3) begin
                check_val($sformatf("c6_wr_%0d", w6), 32'({rf_write_reg, rf_write_data}),
                          32'({s6_reg[w6], s6_data[w6]}));
                w6++;
            end
        end
        check_val("c6_count_end", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
Write-side initiator for the 8 x 8-bit register file. Collects results from the execute/memory stage through a valid/ready handshake and buffers them in an in-order queue. Drains one entry per clock onto the register file write port (write enable, write register number, write data). Exports a pending-write mask and youngest-value forwarding for two decode read ports, so decode can bypass or stall on queued writes.

Parameters:
DEPTH, 4, queue entries; integer >= 2, not required to be a power of two
DATA_W, 8, result / register width
ADDR_W, 3, register number width (2**ADDR_W registers)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  reset, synchronous, active-low
in_valid  in  1  producer offers a result this cycle
in_ready  out  1  queue can accept; push occurs when in_valid && in_ready
in_reg  in  ADDR_W  destination register of offered result
in_data  in  DATA_W  offered result value
drain_en  in  1  permission to write the register file this cycle
rf_write_en  out  1  drives register file RegWrite
rf_write_reg  out  ADDR_W  drives register file write register number
rf_write_data  out  DATA_W  drives register file write data
chk_reg_1  in  ADDR_W  decode read register 1 under check
chk_reg_2  in  ADDR_W  decode read register 2 under check
fwd_hit_1  out  1  some queued entry targets chk_reg_1
fwd_data_1  out  DATA_W  youngest queued value for chk_reg_1
fwd_hit_2  out  1  some queued entry targets chk_reg_2
fwd_data_2  out  DATA_W  youngest queued value for chk_reg_2
pending  out  2**ADDR_W  bit r set iff some queued entry targets register r
count  out  clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: circular buffer of DEPTH entries {reg, data}. Head/tail pointers wrap explicitly from DEPTH-1 to 0 (no power-of-two masking). count is registered.
- in_ready = reset && (count < DEPTH). It is combinational from registered count only. No accept on a full cycle, even when a pop happens in the same cycle.
- Push: at the edge where in_valid && in_ready, write {in_reg, in_data} at tail, then advance tail. When in_valid && !in_ready, nothing is stored. The producer holds its data.
- Drain: rf_write_en = reset && drain_en && (count != 0). rf_write_reg and rf_write_data always show the head entry. When count == 0 they show 0.
- Pop: at the edge where rf_write_en == 1, advance head. The register file captures the write at that same edge.
- Latency: an entry pushed at edge N can appear on the rf port in the cycle after edge N. There is no empty-queue bypass.
- Simultaneous push and pop: count unchanged, both pointers advance, order preserved.
- Ordering: strict FIFO. Multiple entries to the same register are all written, oldest first.
- All 2**ADDR_W registers are writable. There is no hardwired-zero register.
- pending: combinational OR over occupied entries. It includes the head entry being written this cycle.
- Forwarding, per port k:
  - fwd_hit_k = 1 iff any occupied entry has reg == chk_reg_k.
  - fwd_data_k = data of the youngest (closest to tail) matching entry.
  - When fwd_hit_k = 0, fwd_data_k = 0.
  - The head entry written this cycle still counts as a hit.
- Reset (reset == 0 at an edge): head = tail = count = 0, and all entries are invalidated. No push or pop occurs at that edge.
- While reset is low: in_ready = 0 and rf_write_en = 0, so the queue never contends with the register file reset preload.
- Outputs at/after reset: in_ready = 0 during reset, 1 from the first cycle after release. rf_write_en = 0; rf_write_reg = 0; rf_write_data = 0; pending = 0; count = 0; fwd_hit_k = 0; fwd_data_k = 0.
- Reset mid-operation: queued entries are discarded, never written.
- drain_en low: the queue holds its contents, pushes continue until full, forwarding stays valid.

Test Plan:
1. Reset, then push r3=0xA5 with drain_en=1 -> next cycle rf_write_en=1, rf_write_reg=3, rf_write_data=0xA5 for exactly 1 cycle; pending=0x08 that cycle; then count=0, pending=0x00.
2. drain_en=0, push r1=0x11, r2=0x22, r1=0x33, r7=0x77 -> count=4, in_ready=0; 5th push r4=0x44 ignored; pending=0x86; chk_reg_1=1 -> hit, 0x33; chk_reg_2=5 -> hit 0, data 0x00.
3. From case 2, set drain_en=1 -> rf writes (1,0x11),(2,0x22),(1,0x33),(7,0x77) in 4 consecutive cycles. After the 3rd write chk r1 -> hit 0. in_ready=1 from the cycle after the 1st pop.
4. count=2, drain_en=1, push in the same cycle as a pop -> count stays 2. Stream 10 pushes back-to-back with drain_en=1 -> 10 rf writes in order, with tail and head wrapping at DEPTH, none lost or duplicated.
5. Queue 3 entries with drain_en=0, assert reset low 1 cycle with drain_en=1 and in_valid=1 -> rf_write_en=0 and in_ready=0 during reset; after release count=0, pending=0, no stale writes appear.
6. drain_en toggling 1,0,1,0 with 3 entries queued -> writes only in drain_en=1 cycles, order intact, forwarding unchanged during hold cycles.
